// File: rtl/fifo_width_converter_param.sv
// fifo_width_converter_param: unit-granular FIFO with independent write/read word widths, occupancy counts, flush and error pulses.
module fifo_width_converter_param #(
  parameter int WR_WIDTH   = 8,
  parameter int RD_WIDTH   = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  flush_i,
  input  logic                  write_i,
  input  logic [WR_WIDTH-1:0]   write_data_i,
  input  logic                  read_i,
  output logic [RD_WIDTH-1:0]   read_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   rd_avail_o,
  output logic [ADDR_WIDTH:0]   wr_free_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int UNIT_W    = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
  localparam int MAX_W     = (WR_WIDTH < RD_WIDTH) ? RD_WIDTH : WR_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int WR_RATIO  = WR_WIDTH / UNIT_W;
  localparam int RD_RATIO  = RD_WIDTH / UNIT_W;
  localparam int MAX_RATIO = MAX_W / UNIT_W;
  localparam int CW        = ADDR_WIDTH + 1;
  localparam int WR_SH     = $clog2(WR_RATIO);
  localparam int RD_SH     = $clog2(RD_RATIO);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] WR_C    = CW'(WR_RATIO);
  localparam logic [CW-1:0] RD_C    = CW'(RD_RATIO);
  if ((MAX_W % UNIT_W) != 0 || (MAX_RATIO & (MAX_RATIO - 1)) != 0 || DEPTH < 2 * MAX_RATIO) begin : g_illegal
    $error("fifo_width_converter_param: illegal WR_WIDTH/RD_WIDTH/ADDR_WIDTH combination");
  end
  logic [UNIT_W-1:0]     r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf, r_udf;
  logic                  w_wr_acc, w_rd_acc;
  logic [RD_WIDTH-1:0]   w_rd_word;
  assign empty_o     = r_count < RD_C;
  assign full_o      = (DEPTH_C - r_count) < WR_C;
  assign rd_avail_o  = r_count >> RD_SH;
  assign wr_free_o   = (DEPTH_C - r_count) >> WR_SH;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_udf;
  assign w_wr_acc    = write_i && !full_o && !flush_i;
  assign w_rd_acc    = read_i && !empty_o && !flush_i;
  assign read_data_o = empty_o ? '0 : w_rd_word;
  for (genvar i = 0; i < RD_RATIO; i++) begin : g_rd
    assign w_rd_word[i*UNIT_W +: UNIT_W] = r_mem[r_rd_ptr + ADDR_WIDTH'(i)];
  end
  // Pointers stay ratio-aligned, so a multi-unit write never straddles the wrap.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc)
      for (int i = 0; i < WR_RATIO; i++)
        r_mem[r_wr_ptr + ADDR_WIDTH'(i)] <= write_data_i[i*UNIT_W +: UNIT_W];
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_ovf <= write_i && full_o && !flush_i;
      r_udf <= read_i && empty_o && !flush_i;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= w_wr_acc ? r_wr_ptr + ADDR_WIDTH'(WR_RATIO) : r_wr_ptr;
        r_rd_ptr <= w_rd_acc ? r_rd_ptr + ADDR_WIDTH'(RD_RATIO) : r_rd_ptr;
        r_count  <= r_count + (w_wr_acc ? WR_C : '0) - (w_rd_acc ? RD_C : '0);
      end
    end
  end
endmodule

// File: tb/tb_fifo_width_converter_param.sv
// tb_fifo_width_converter_param: scoreboard bench for an 8->4 and a 4->16 instance of the width converter.
module tb_fifo_width_converter_param;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic       a_fl = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_wd = 0;
  logic [3:0] a_rdata;
  logic       a_empty, a_full, a_ovf, a_udf;
  logic [4:0] a_avail, a_free;
  logic        b_fl = 0, b_wr = 0, b_rd = 0;
  logic [3:0]  b_wd = 0;
  logic [15:0] b_rdata;
  logic        b_empty, b_full, b_ovf, b_udf;
  logic [4:0]  b_avail, b_free;
  fifo_width_converter_param #(.WR_WIDTH(8), .RD_WIDTH(4), .ADDR_WIDTH(4)) u_a (
    .clk_i(clk), .reset_ni(rst_n), .flush_i(a_fl), .write_i(a_wr), .write_data_i(a_wd),
    .read_i(a_rd), .read_data_o(a_rdata), .empty_o(a_empty), .full_o(a_full),
    .rd_avail_o(a_avail), .wr_free_o(a_free), .overflow_o(a_ovf), .underflow_o(a_udf));
  fifo_width_converter_param #(.WR_WIDTH(4), .RD_WIDTH(16), .ADDR_WIDTH(4)) u_b (
    .clk_i(clk), .reset_ni(rst_n), .flush_i(b_fl), .write_i(b_wr), .write_data_i(b_wd),
    .read_i(b_rd), .read_data_o(b_rdata), .empty_o(b_empty), .full_o(b_full),
    .rd_avail_o(b_avail), .wr_free_o(b_free), .overflow_o(b_ovf), .underflow_o(b_udf));
  int n_tests = 0, n_fail = 0;
  int ma = 0, mb = 0;
  logic [3:0]  qa [$];
  logic [15:0] qb [$];
  logic [3:0]  ea;
  logic [15:0] eb;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && a_rd && !a_fl && !a_empty) begin
      n_tests++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_pop: got 0x%0h with nothing expected", a_rdata);
      end else begin
        ea = qa.pop_front();
        if (a_rdata !== ea) begin
          n_fail++;
          $display("FAIL a_data: got 0x%0h expected 0x%0h", a_rdata, ea);
        end
      end
    end
    if (rst_n && b_rd && !b_fl && !b_empty) begin
      n_tests++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_pop: got 0x%0h with nothing expected", b_rdata);
      end else begin
        eb = qb.pop_front();
        if (b_rdata !== eb) begin
          n_fail++;
          $display("FAIL b_data: got 0x%0h expected 0x%0h", b_rdata, eb);
        end
      end
    end
  end
  task automatic flags_a();
    chk("a_empty", a_empty, ma < 1);
    chk("a_full", a_full, (16 - ma) < 2);
    chk("a_avail", a_avail, ma);
    chk("a_free", a_free, (16 - ma) / 2);
    if (ma == 0) chk("a_rdata_empty", a_rdata, 0);
  endtask
  task automatic step_a(input logic w, input logic [7:0] d, input logic r, input logic f);
    bit full_m, empty_m, wacc, racc;
    full_m  = (16 - ma) < 2;
    empty_m = ma < 1;
    wacc = w && !full_m && !f;
    racc = r && !empty_m && !f;
    a_wr = w; a_wd = d; a_rd = r; a_fl = f;
    if (f) begin
      ma = 0;
      qa.delete();
    end else begin
      if (wacc) begin
        qa.push_back(d[3:0]);
        qa.push_back(d[7:4]);
      end
      ma += (wacc ? 2 : 0) - (racc ? 1 : 0);
    end
    @(posedge clk); #1;
    a_wr = 0; a_rd = 0; a_fl = 0;
    chk("a_ovf", a_ovf, w && full_m && !f);
    chk("a_udf", a_udf, r && empty_m && !f);
    flags_a();
  endtask
  task automatic step_b(input logic w, input logic [3:0] d, input logic r);
    bit full_m, empty_m, wacc, racc;
    full_m  = mb >= 16;
    empty_m = mb < 4;
    wacc = w && !full_m;
    racc = r && !empty_m;
    b_wr = w; b_wd = d; b_rd = r;
    mb += (wacc ? 1 : 0) - (racc ? 4 : 0);
    @(posedge clk); #1;
    b_wr = 0; b_rd = 0;
    chk("b_ovf", b_ovf, w && full_m);
    chk("b_udf", b_udf, r && empty_m);
    chk("b_empty", b_empty, mb < 4);
    chk("b_full", b_full, mb >= 16);
    chk("b_avail", b_avail, mb / 4);
    chk("b_free", b_free, 16 - mb);
  endtask
  initial begin
    #3;
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_avail", a_avail, 0);
    chk("rst_free", a_free, 8);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_udf", a_udf, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_b_free", b_free, 16);
    #9 rst_n = 1;
    @(posedge clk); #1;
    step_a(1, 8'hA5, 0, 0);
    step_a(1, 8'h3C, 0, 0);
    repeat (4) step_a(0, 8'h00, 1, 0);
    chk("t1_empty", a_empty, 1);
    for (int i = 1; i <= 8; i++) step_a(1, 8'(i), 0, 0);
    chk("fill_full", a_full, 1);
    chk("fill_free", a_free, 0);
    chk("fill_avail", a_avail, 16);
    step_a(1, 8'hFF, 0, 0);
    chk("ovf_ninth", a_ovf, 1);
    step_a(1, 8'hEE, 1, 0);
    chk("rw_full_ovf", a_ovf, 1);
    chk("rw_full_avail", a_avail, 15);
    chk("rw_full_full", a_full, 1);
    repeat (15) step_a(0, 8'h00, 1, 0);
    step_a(0, 8'h00, 1, 0);
    chk("udf_pulse", a_udf, 1);
    step_a(0, 8'h00, 0, 0);
    chk("udf_drop", a_udf, 0);
    step_a(1, 8'h03, 0, 0);
    for (int i = 1; i < 40; i++) begin
      step_a(1, 8'(i * 37 + 3), 1, 0);
      step_a(0, 8'h00, 1, 0);
    end
    repeat (2) step_a(0, 8'h00, 1, 0);
    chk("wrap_empty", a_empty, 1);
    repeat (3) step_b(1, 4'(mb + 1), 0);
    chk("b_partial_empty", b_empty, 1);
    chk("b_partial_avail", b_avail, 0);
    qb.push_back(16'h4321);
    step_b(1, 4'h4, 0);
    chk("b_ready_empty", b_empty, 0);
    chk("b_ready_data", b_rdata, 16'h4321);
    step_b(0, 4'h0, 1);
    step_b(0, 4'h0, 1);
    chk("b_udf_pulse", b_udf, 1);
    for (int i = 0; i < 5; i++) step_a(1, 8'(8'h10 + i), 0, 0);
    chk("pre_rst_avail", a_avail, 10);
    #2 rst_n = 0;
    #1;
    chk("async_empty", a_empty, 1);
    chk("async_free", a_free, 8);
    chk("async_avail", a_avail, 0);
    ma = 0; mb = 0;
    qa.delete(); qb.delete();
    #1 rst_n = 1;
    @(posedge clk); #1;
    flags_a();
    for (int i = 0; i < 5; i++) step_a(1, 8'(8'h20 + i), 0, 0);
    step_a(1, 8'h99, 0, 1);
    chk("flush_avail", a_avail, 0);
    chk("flush_empty", a_empty, 1);
    chk("flush_no_ovf", a_ovf, 0);
    step_a(1, 8'h5A, 0, 0);
    repeat (2) step_a(0, 8'h00, 1, 0);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_width_converter_param.md
Name: fifo_width_converter_param

Overview:
- Parametrised successor to the fixed 8-to-4 width-converting FIFO.
- Write and read widths are independent parameters, so the block supports wide-to-narrow, narrow-to-wide and equal-width operation.
- Adds occupancy counts in native word units, a synchronous flush, and overflow/underflow pulses.
- Sits between producer and consumer datapaths running on the same clock.

Parameters:
- WR_WIDTH, 8, write word width in bits.
- RD_WIDTH, 4, read word width in bits.
- ADDR_WIDTH, 4, log2 of storage depth, counted in units of UNIT_W = min(WR_WIDTH, RD_WIDTH) bits.
- Derived, not overridable: DEPTH = 2**ADDR_WIDTH units; WR_RATIO = WR_WIDTH/UNIT_W; RD_RATIO = RD_WIDTH/UNIT_W.
- Legal configurations: max(WR_WIDTH, RD_WIDTH)/UNIT_W is a power of two, and DEPTH >= 2*max(WR_RATIO, RD_RATIO). Illegal configurations fail elaboration via $error.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of contents.
- write_i  in  1  write request.
- write_data_i  in  WR_WIDTH  write word.
- read_i  in  1  read (pop) request.
- read_data_o  out  RD_WIDTH  head read word, show-ahead.
- empty_o  out  1  fewer than RD_RATIO units stored.
- full_o  out  1  fewer than WR_RATIO units free.
- rd_avail_o  out  ADDR_WIDTH+1  complete read words available.
- wr_free_o  out  ADDR_WIDTH+1  write words that fit.
- overflow_o  out  1  one-cycle pulse: write while full.
- underflow_o  out  1  one-cycle pulse: read while empty.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_ni=0, all state clears immediately without waiting for a clock edge:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs: empty_o=1, full_o=0, rd_avail_o=0, wr_free_o=DEPTH/WR_RATIO, overflow_o=0, underflow_o=0, read_data_o=0.
  - Storage array is not reset.
- Storage: DEPTH x UNIT_W register file with asynchronous read. Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. count is ADDR_WIDTH+1 bits, in units.
- Write acceptance: accepted on a rising edge when write_i=1 && !full_o && !flush_i.
  - Writes WR_RATIO consecutive units at wr_ptr, wr_ptr+1, …
  - Slice [UNIT_W-1:0] goes to the lowest address (least-significant slice first).
  - wr_ptr advances by WR_RATIO.
  - Pointers stay ratio-aligned, so a single write never splits across the wrap boundary.
- Read acceptance: accepted when read_i=1 && !empty_o && !flush_i. rd_ptr advances by RD_RATIO.
- read_data_o: concatenation of RD_RATIO units starting at rd_ptr, with the unit at rd_ptr in the LSBs. Forced to 0 while empty_o=1.
- Count update: count_next = count + WR_RATIO*wr_acc − RD_RATIO*rd_acc. Both may be accepted in the same cycle.
- Flag timing:
  - full_o and empty_o are evaluated from registered state at the start of the cycle.
  - A write while full_o=1 is rejected even if a read is accepted in the same cycle; likewise a read while empty_o=1.
  - Flags and counts are combinational from count: rd_avail_o = count/RD_RATIO; wr_free_o = (DEPTH−count)/WR_RATIO.
- Latency: data written at edge k is readable (empty_o=0, read_data_o valid) in the cycle after edge k, provided count then reaches RD_RATIO. There is no extra pipeline stage.
- Partial accumulation (narrow-to-wide): units below RD_RATIO remain stored with empty_o=1 and rd_avail_o=0.
- Error pulses: rejected write_i → overflow_o=1 for exactly the next cycle; rejected read_i → underflow_o=1 for exactly the next cycle. Requests dropped by flush_i do not pulse.
- Flush: flush_i=1 at an edge clears pointers and count (same state as reset) and overrides any simultaneous write or read.
- Equal widths: degenerates to a plain FIFO of DEPTH words.

Test Plan:
- WR=8, RD=4, AW=4, after reset:
  - empty_o=1, full_o=0, rd_avail_o=0, wr_free_o=8.
  - Write 0xA5 then 0x3C; read four times → read_data_o sequence 0x5, 0xA, 0xC, 0x3, then empty_o=1.
- Fill (WR=8, RD=4, AW=4): eight writes of 0x01..0x08 → full_o=1, wr_free_o=0, rd_avail_o=16.
  - Ninth write 0xFF → overflow_o pulses 1 cycle; subsequent reads return 1,0,2,0,…,8,0.
- While full, assert write_i and read_i together:
  - Read accepted; write rejected with overflow_o pulse.
  - Afterwards rd_avail_o=15, full_o=1 (1 unit free < 2).
- WR=4, RD=16, AW=4:
  - Write 0x1, 0x2, 0x3 → empty_o=1, rd_avail_o=0.
  - Fourth write 0x4 → next cycle empty_o=0, read_data_o=0x4321.
  - Read on empty → underflow_o pulse.
- Wrap-around, WR=8, RD=4: stream 40 bytes with continuous simultaneous read/write → read nibbles match the write stream in order and no flag glitches.
- Reset and flush mid-operation:
  - With 5 bytes stored, drive reset_ni low between clock edges → empty_o=1, wr_free_o=8 immediately (before the next edge).
  - Repeat the scenario using flush_i with write_i=1 → count=0, and the write is discarded.
